rst_req_ctrl: RTL and testbench

Reset-request sequencer that drives cpu_pad_soft_rst[1:0] into mcu_reset.
- Collects core and system reset requests from software, the debugger and the watchdog.
- Arbitrates them by priority and holds the winning request long enough for mcu_reset's 2-cycle qualifier.
- Enforces a cooldown between requests and records the reset cause in a sticky register.
- Lives in the power-on reset domain (mcu_rstn), so its state survives the core and system resets it requests.

---
 rtl/rst_req_ctrl_if.sv | 24 ++
 rtl/rst_req_ctrl.sv | 176 +++++++++++++++++
 tb/tb_rst_req_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/rst_req_ctrl_if.sv
// rst_req_ctrl_if: request/status bundle between reset-request sources and rst_req_ctrl.
// The slave side is the sequencer; the master side is whatever drives the requests.
interface rst_req_ctrl_if;
  logic       sw_core_req;
  logic       sw_sys_req;
  logic       dbg_core_req;
  logic       dbg_sys_req;
  logic       wdt_rst_req;
  logic       cause_clr;
  logic [1:0] cpu_pad_soft_rst;
  logic       rst_busy;
  logic [4:0] rst_cause;
  logic [7:0] rst_cnt;

  modport slave (
    input  sw_core_req, sw_sys_req, dbg_core_req, dbg_sys_req, wdt_rst_req, cause_clr,
    output cpu_pad_soft_rst, rst_busy, rst_cause, rst_cnt
  );

  modport master (
    output sw_core_req, sw_sys_req, dbg_core_req, dbg_sys_req, wdt_rst_req, cause_clr,
    input  cpu_pad_soft_rst, rst_busy, rst_cause, rst_cnt
  );
endinterface

// File: rtl/rst_req_ctrl.sv
// rst_req_ctrl: reset-request sequencer feeding cpu_pad_soft_rst into mcu_reset.
// Arbitrates core/system reset requests, holds the winner for HOLD_CYCLES, enforces
// a GAP_CYCLES cooldown and keeps a sticky cause register. Runs in the power-on
// domain so it survives the resets it requests.
// Optional feature macro: RST_REQ_CNT_EN (saturating count of system resets on rst_cnt).
module rst_req_ctrl #(
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4,
  parameter int CNT_W       = 8
) (
  input logic          sys_clk,
  input logic          mcu_rstn,
  rst_req_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ASSERT_CORE = 2'd1,
    ASSERT_SYS  = 2'd2,
    COOLDOWN    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [4:0]       pend;
  logic [4:0]       req_live;
  logic [4:0]       arb_vec;
  logic [4:0]       cause_set;
  logic [4:0]       cause_q;
  logic             sys_any, core_any, live_sys;
  logic             enter_sys, enter_core;
  logic [1:0]       soft_rst_q, soft_rst_nxt;
  logic             busy_q, busy_nxt;

  // Bit order matches rst_cause: [0] sw_core, [1] dbg_core, [2] sw_sys, [3] dbg_sys, [4] wdt.
  // Only the system/core category of the winner is visible on the pads, so the
  // priority order inside a category reduces to "any system source beats any core source".
  assign req_live  = {bus.wdt_rst_req, bus.dbg_sys_req, bus.sw_sys_req,
                      bus.dbg_core_req, bus.sw_core_req};
  assign arb_vec   = req_live | pend;
  assign sys_any   = |arb_vec[4:2];
  assign core_any  = |arb_vec[1:0];
  assign live_sys  = |req_live[4:2];
  assign enter_sys  = (state_nxt == ASSERT_SYS) && (state != ASSERT_SYS);
  assign enter_core = (state_nxt == ASSERT_CORE) && (state != ASSERT_CORE);

  // State register plus registered pad/busy outputs computed from the next state.
  always_ff @(posedge sys_clk or negedge mcu_rstn) begin
    if (!mcu_rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      soft_rst_q <= 2'b00;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      soft_rst_q <= soft_rst_nxt;
      busy_q     <= busy_nxt;
    end
  end

  // Next-state and hold/gap counter: a core hold escalates to system on any live system request.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (sys_any) begin
          state_nxt = ASSERT_SYS;
        end else if (core_any) begin
          state_nxt = ASSERT_CORE;
        end
      end
      ASSERT_CORE: begin
        if (live_sys) begin
          state_nxt = ASSERT_SYS;
          cnt_nxt   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = COOLDOWN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ASSERT_SYS: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = COOLDOWN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      COOLDOWN: begin
        if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode of the next state so the pads are a clean flop output.
  always_comb begin
    soft_rst_nxt = 2'b00;
    busy_nxt     = (state_nxt != IDLE);
    case (state_nxt)
      ASSERT_CORE: soft_rst_nxt = 2'b01;
      ASSERT_SYS:  soft_rst_nxt = 2'b10;
      default:     soft_rst_nxt = 2'b00;
    endcase
  end

  // Pending latch: only cooldown requests need remembering; grants clear what they service.
  always_ff @(posedge sys_clk or negedge mcu_rstn) begin
    if (!mcu_rstn) begin
      pend <= '0;
    end else if (enter_sys) begin
      pend <= '0;
    end else if (enter_core) begin
      pend <= pend & 5'b11100;
    end else if (state == COOLDOWN) begin
      pend <= pend | req_live;
    end
  end

  // Cause bits: everything seen at an IDLE grant, plus anything absorbed while asserting.
  always_comb begin
    cause_set = '0;
    case (state)
      IDLE:                    cause_set = arb_vec;
      ASSERT_CORE, ASSERT_SYS: cause_set = req_live;
      default:                 cause_set = '0;
    endcase
  end

  // Sticky cause register; a same-cycle set survives cause_clr for that bit.
  always_ff @(posedge sys_clk or negedge mcu_rstn) begin
    if (!mcu_rstn) begin
      cause_q <= '0;
    end else begin
      cause_q <= (bus.cause_clr ? 5'b00000 : cause_q) | cause_set;
    end
  end

  assign bus.cpu_pad_soft_rst = soft_rst_q;
  assign bus.rst_busy         = busy_q;
  assign bus.rst_cause        = cause_q;

`ifdef RST_REQ_CNT_EN
  logic [7:0] sys_cnt_q;

  // Saturating count of system-reset grants, cleared only by the power-on reset.
  always_ff @(posedge sys_clk or negedge mcu_rstn) begin
    if (!mcu_rstn) begin
      sys_cnt_q <= 8'h00;
    end else if (enter_sys && (sys_cnt_q != 8'hFF)) begin
      sys_cnt_q <= sys_cnt_q + 8'h01;
    end
  end

  assign bus.rst_cnt = sys_cnt_q;
`else
  assign bus.rst_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_rst_req_ctrl.sv
// tb_rst_req_ctrl: directed self-checking bench for rst_req_ctrl (HOLD=16, GAP=4).
// Build with +define+RST_REQ_CNT_EN to exercise the system-reset counter.
module tb_rst_req_ctrl;
  logic sys_clk;
  logic mcu_rstn;
  int   checks;
  int   errors;
  int   exp_cnt;

  rst_req_ctrl_if bus();

  rst_req_ctrl #(
    .HOLD_CYCLES(16),
    .GAP_CYCLES (4),
    .CNT_W      (8)
  ) dut (
    .sys_clk (sys_clk),
    .mcu_rstn(mcu_rstn),
    .bus     (bus)
  );

  // Free-running system clock, 10 time units per cycle.
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Hard time limit so a stuck design still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] time limit");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Drive a one-cycle request pattern {wdt, dbg_sys, sw_sys, dbg_core, sw_core} plus cause_clr.
  task automatic applyStimulus(input logic [4:0] reqs, input logic clr);
    bus.sw_core_req  = reqs[0];
    bus.dbg_core_req = reqs[1];
    bus.sw_sys_req   = reqs[2];
    bus.dbg_sys_req  = reqs[3];
    bus.wdt_rst_req  = reqs[4];
    bus.cause_clr    = clr;
    step();
    bus.sw_core_req  = 1'b0;
    bus.dbg_core_req = 1'b0;
    bus.sw_sys_req   = 1'b0;
    bus.dbg_sys_req  = 1'b0;
    bus.wdt_rst_req  = 1'b0;
    bus.cause_clr    = 1'b0;
  endtask

  // Count consecutive cycles the pads show val, stepping past the run.
  task automatic runLength(input logic [1:0] val, output int len);
    len = 0;
    while (bus.cpu_pad_soft_rst == val && len < 200) begin
      len++;
      step();
    end
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (bus.rst_busy && n < 100) begin
      n++;
      step();
    end
    checkOutput(tag, 32'(bus.rst_busy), 32'd0);
  endtask

  function automatic logic [31:0] expRstCnt();
`ifdef RST_REQ_CNT_EN
    return 32'(exp_cnt);
`else
    return 32'd0;
`endif
  endfunction

  initial begin
    int len;
    int n;
    logic saw_core;
    checks  = 0;
    errors  = 0;
    exp_cnt = 0;
    mcu_rstn         = 1'b0;
    bus.sw_core_req  = 1'b0;
    bus.sw_sys_req   = 1'b0;
    bus.dbg_core_req = 1'b0;
    bus.dbg_sys_req  = 1'b0;
    bus.wdt_rst_req  = 1'b0;
    bus.cause_clr    = 1'b0;
    repeat (3) step();

    checkOutput("reset_pads",  32'(bus.cpu_pad_soft_rst), 32'd0);
    checkOutput("reset_busy",  32'(bus.rst_busy), 32'd0);
    checkOutput("reset_cause", 32'(bus.rst_cause), 32'd0);
    checkOutput("reset_cnt",   32'(bus.rst_cnt), 32'd0);

    mcu_rstn = 1'b1;
    repeat (9) step();

    // Core request: 16 cycles of 2'b01, then 4 cooldown cycles before IDLE.
    applyStimulus(5'b00001, 1'b0);
    checkOutput("core_first", 32'(bus.cpu_pad_soft_rst), 32'h1);
    runLength(2'b01, len);
    checkOutput("core_hold_len", 32'(len), 32'd16);
    checkOutput("core_release", 32'(bus.cpu_pad_soft_rst), 32'h0);
    checkOutput("core_cool_busy", 32'(bus.rst_busy), 32'd1);
    repeat (3) step();
    checkOutput("core_cool_end_busy", 32'(bus.rst_busy), 32'd1);
    step();
    checkOutput("core_idle_busy", 32'(bus.rst_busy), 32'd0);
    checkOutput("core_cause", 32'(bus.rst_cause), 32'h01);

    // Core and watchdog together: system wins, core recorded as absorbed.
    applyStimulus(5'b00000, 1'b1);
    checkOutput("clr_cause", 32'(bus.rst_cause), 32'h00);
    applyStimulus(5'b10001, 1'b0);
    exp_cnt++;
    checkOutput("mix_first", 32'(bus.cpu_pad_soft_rst), 32'h2);
    runLength(2'b10, len);
    checkOutput("mix_hold_len", 32'(len), 32'd16);
    checkOutput("mix_release", 32'(bus.cpu_pad_soft_rst), 32'h0);
    checkOutput("mix_cause", 32'(bus.rst_cause), 32'h11);
    checkOutput("mix_cnt", 32'(bus.rst_cnt), expRstCnt());
    waitIdle("mix_idle");

    // Debugger core, then debugger system 5 cycles later: escalation.
    applyStimulus(5'b00000, 1'b1);
    applyStimulus(5'b00010, 1'b0);
    n = 0;
    repeat (4) begin
      if (bus.cpu_pad_soft_rst == 2'b01) n++;
      step();
    end
    if (bus.cpu_pad_soft_rst == 2'b01) n++;
    applyStimulus(5'b01000, 1'b0);
    exp_cnt++;
    checkOutput("esc_core_len", 32'(n), 32'd5);
    checkOutput("esc_sys_first", 32'(bus.cpu_pad_soft_rst), 32'h2);
    runLength(2'b10, len);
    checkOutput("esc_sys_len", 32'(len), 32'd16);
    saw_core = 1'b0;
    repeat (12) begin
      if (bus.cpu_pad_soft_rst == 2'b01) saw_core = 1'b1;
      step();
    end
    checkOutput("esc_no_core", 32'(saw_core), 32'd0);
    checkOutput("esc_cause", 32'(bus.rst_cause), 32'h0A);
    checkOutput("esc_cnt", 32'(bus.rst_cnt), expRstCnt());
    waitIdle("esc_idle");

    // System request during cooldown is held pending and granted from IDLE.
    applyStimulus(5'b00000, 1'b1);
    applyStimulus(5'b00001, 1'b0);
    runLength(2'b01, len);
    checkOutput("cool_core_len", 32'(len), 32'd16);
    applyStimulus(5'b00100, 1'b0);
    checkOutput("cool_pend_quiet", 32'(bus.cpu_pad_soft_rst), 32'h0);
    n = 0;
    while (bus.rst_busy && n < 50) begin
      n++;
      step();
    end
    checkOutput("cool_to_idle", 32'(n), 32'd3);
    checkOutput("cool_idle_pads", 32'(bus.cpu_pad_soft_rst), 32'h0);
    step();
    exp_cnt++;
    checkOutput("cool_pend_grant", 32'(bus.cpu_pad_soft_rst), 32'h2);
    runLength(2'b10, len);
    checkOutput("cool_sys_len", 32'(len), 32'd16);
    checkOutput("cool_cause", 32'(bus.rst_cause), 32'h05);
    waitIdle("cool_idle");

    // cause_clr in the same cycle as a new grant keeps the granted bit.
    applyStimulus(5'b00100, 1'b1);
    exp_cnt++;
    checkOutput("clr_set_cause", 32'(bus.rst_cause), 32'h04);
    checkOutput("clr_set_pads", 32'(bus.cpu_pad_soft_rst), 32'h2);
    checkOutput("clr_keeps_cnt", 32'(bus.rst_cnt), expRstCnt());
    waitIdle("clr_idle");

    // Watchdog held high: periodic system resets, 16 on, then 4 cooldown + 1 IDLE off.
    applyStimulus(5'b00000, 1'b1);
    bus.wdt_rst_req = 1'b1;
    step();
    exp_cnt++;
    for (int i = 0; i < 14; i++) begin
      runLength(2'b10, len);
      checkOutput($sformatf("wdt_on_%0d", i), 32'(len), 32'd16);
      runLength(2'b00, len);
      checkOutput($sformatf("wdt_off_%0d", i), 32'(len), 32'd5);
      exp_cnt++;
    end
    checkOutput("wdt_cause", 32'(bus.rst_cause), 32'h10);
    checkOutput("wdt_cnt", 32'(bus.rst_cnt), expRstCnt());

    // Power-on reset in the middle of a hold drops everything at once.
    repeat (5) step();
    checkOutput("prerst_pads", 32'(bus.cpu_pad_soft_rst), 32'h2);
    #2;
    mcu_rstn = 1'b0;
    #1;
    checkOutput("midrst_pads",  32'(bus.cpu_pad_soft_rst), 32'h0);
    checkOutput("midrst_busy",  32'(bus.rst_busy), 32'd0);
    checkOutput("midrst_cause", 32'(bus.rst_cause), 32'h00);
    checkOutput("midrst_cnt",   32'(bus.rst_cnt), 32'd0);
    bus.wdt_rst_req = 1'b0;
    step();
    mcu_rstn = 1'b1;
    repeat (3) step();
    checkOutput("postrst_pads", 32'(bus.cpu_pad_soft_rst), 32'h0);
    checkOutput("postrst_busy", 32'(bus.rst_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
